usb_tx_serializer: RTL

Downstream stage of the FFT output buffer: accepts packed 32-bit FFT samples (`{re[15:0], im[15:0]}`) with a per-word valid strobe, queues them in an internal FIFO and streams them MSB-first as bytes into an FT245-style synchronous USB FIFO interface. It also:
- groups words into frames of `FRAME_LEN` words;
- pulses `frame_done` when the last byte of each frame has been transferred;
- flags any word lost to FIFO overflow.

---
 rtl/usb_tx_serializer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer
//   Buffers packed 32-bit FFT samples {re[15:0], im[15:0]} in a FIFO and
//   streams them MSB-first, one byte per transfer, into an FT245-style
//   synchronous USB FIFO. Words are grouped into frames of FRAME_LEN words.
//
// Parameters
//   DEPTH      FIFO depth in words (power of two, >= 4)
//   FRAME_LEN  words per frame (>= 1)
//
// Ports
//   CLK         in   single clock, rising edge
//   reset       in   asynchronous active-low reset
//   data_in     in   packed sample, [31:16] real, [15:0] imaginary
//   data_valid  in   data_in valid this cycle (no backpressure)
//   usb_txe_n   in   USB FIFO can accept a byte when 0
//   usb_wr_n    out  registered active-low byte write strobe
//   usb_data    out  registered byte to USB
//   fifo_level  out  words currently held in the FIFO
//   overflow    out  sticky: a valid word was dropped while full
//   frame_done  out  one-cycle pulse after the last byte of a frame
//
// Build option
//   USB_FRAME_HEADER_EN  when defined, each frame is preceded by the header
//                        bytes A5 5A frame_cnt[15:8] frame_cnt[7:0].

module usb_tx_serializer #(
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned FRAME_LEN = 1024
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [31:0]              data_in,
    input  logic                     data_valid,
    input  logic                     usb_txe_n,
    output logic                     usb_wr_n,
    output logic [7:0]               usb_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     frame_done
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned WCW = $clog2(FRAME_LEN) + 1;
    localparam logic [AW:0]    FULL_LVL  = (AW + 1)'(DEPTH);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_LEN - 1);

`ifdef USB_FRAME_HEADER_EN
    typedef enum logic [1:0] {IDLE, SEND, HDR} state_e;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_e;
`endif

    state_e          state_q, state_d;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [31:0]     shreg_q, shreg_d;
    logic [1:0]      idx_q, idx_d;
    logic            wr_n_q, wr_n_d;
    logic [7:0]      data_q, data_d;
    logic            ovf_q, ovf_d;
    logic            fd_q, fd_d;
    logic [WCW-1:0]  word_cnt_q, word_cnt_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    logic            xfer, empty, full, pop, push, wrap;
    logic [31:0]     rd_word;

    always_comb begin
        xfer    = !wr_n_q && !usb_txe_n;
        empty   = (count_q == '0);
        full    = (count_q == FULL_LVL);
        rd_word = mem[rd_ptr_q];

        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        wr_n_d      = wr_n_q;
        data_d      = data_q;
        fd_d        = 1'b0;
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pop         = 1'b0;
        wrap        = 1'b0;

        case (state_q)
            IDLE: begin
                wr_n_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = rd_word;
                    idx_d   = 2'd0;
                    wr_n_d  = 1'b0;
                    state_d = SEND;
                    data_d  = rd_word[31:24];
`ifdef USB_FRAME_HEADER_EN
                    // Word is parked in the shift register while the header goes out.
                    if (word_cnt_q == '0) begin
                        state_d = HDR;
                        data_d  = 8'hA5;
                    end
`endif
                end
            end
`ifdef USB_FRAME_HEADER_EN
            HDR: begin
                if (xfer) begin
                    if (idx_q == 2'd3) begin
                        state_d = SEND;
                        idx_d   = 2'd0;
                        data_d  = shreg_q[31:24];
                    end else begin
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd0:    data_d = 8'h5A;
                            2'd1:    data_d = frame_cnt_q[15:8];
                            default: data_d = frame_cnt_q[7:0];
                        endcase
                    end
                end
            end
`endif
            default: begin // SEND
                if (xfer) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd0:    data_d = shreg_q[23:16];
                            2'd1:    data_d = shreg_q[15:8];
                            default: data_d = shreg_q[7:0];
                        endcase
                    end else begin
                        wrap  = (word_cnt_q == LAST_WORD);
                        idx_d = 2'd0;
                        if (wrap) begin
                            word_cnt_d  = '0;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            fd_d        = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                        // Chain straight into the next word to keep 1 byte/clock.
                        if (!empty) begin
                            pop     = 1'b1;
                            shreg_d = rd_word;
                            data_d  = rd_word[31:24];
                            state_d = SEND;
`ifdef USB_FRAME_HEADER_EN
                            if (wrap) begin
                                state_d = HDR;
                                data_d  = 8'hA5;
                            end
`endif
                        end else begin
                            wr_n_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
        endcase

        // A pop on the same edge frees a slot, so a full FIFO still accepts.
        push     = data_valid && (!full || pop);
        ovf_d    = ovf_q || (data_valid && full && !pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shreg_q     <= '0;
            idx_q       <= '0;
            wr_n_q      <= 1'b1;
            data_q      <= '0;
            ovf_q       <= 1'b0;
            fd_q        <= 1'b0;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            wr_n_q      <= wr_n_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
            fd_q        <= fd_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign usb_wr_n   = wr_n_q;
    assign usb_data   = data_q;
    assign fifo_level = count_q;
    assign overflow   = ovf_q;
    assign frame_done = fd_q;

endmodule
